alu_cmd_seq: RTL and testbench

Command front-end and result stage for the 8-bit ALU datapath. Accepts ALU commands over a valid/ready channel, reads operands from a 4-entry by 8-bit register file, drives the combinational `alu8` block, and writes the result back to the register file. Registers each result with its Z/C/V flags into a one-entry output stage with valid/ready handoff downstream. Also keeps a sticky flag register and a saturating operation counter for status readout.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu8.sv | 51 +++++
 rtl/alu_cmd_seq.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU datapath: opcodes, flag bit positions and
// the default register-index width.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    localparam int unsigned REG_IDX_W = 2;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU producing result Y and Z/C/V flags.
// C is carry (ADD), borrow (SUB) or the shifted-out bit (SHL/SHR); V only on ADD/SUB.
module alu8
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       z,
    output logic       c,
    output logic       v
);

    logic [8:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[7:0];
                c   = sum[8];
                v   = (a[7] == b[7]) && (y[7] != a[7]);
            end
            OP_SUB: begin
                y = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            OP_SHR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            OP_PASS: y = a;
            default: y = a;
        endcase
        z = (y == 8'h00);
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command front-end: register file, operand select, writeback, one-entry result
// stage with valid/ready, sticky flags and a saturating op counter.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int unsigned NREG  = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned IdxW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [2:0]       cmd_op,
    input  logic [IdxW-1:0]  cmd_rd,
    input  logic [IdxW-1:0]  cmd_rs1,
    input  logic [IdxW-1:0]  cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [7:0]       cmd_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [IdxW-1:0]  res_rd,
    output logic [2:0]       res_flags,
    output logic [2:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    logic [7:0]       regs_q [NREG];
    logic [7:0]       regs_d [NREG];
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic [IdxW-1:0]  res_rd_q, res_rd_d;
    logic [2:0]       res_flags_q, res_flags_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic       cmd_acc, alu_acc, handoff, wr_ok;
    logic [7:0] op_a, op_b, alu_y;
    logic       alu_z, alu_c, alu_v;
    logic [2:0] alu_flags;

    // Out-of-range indices (only possible when NREG is not a power of two) read as zero.
    function automatic logic [7:0] rf_read(input logic [IdxW-1:0] idx);
        if (int'(idx) < int'(NREG)) begin
            return regs_q[idx];
        end
        return 8'h00;
    endfunction

    assign cmd_ready = !res_valid_q || res_ready;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign alu_acc   = cmd_acc && !cmd_ld;
    assign handoff   = res_valid_q && res_ready;
    assign wr_ok     = int'(cmd_rd) < int'(NREG);

    assign op_a = rf_read(cmd_rs1);
    assign op_b = cmd_imm_en ? cmd_imm : rf_read(cmd_rs2);

    alu8 u_alu8 (
        .a  (op_a),
        .b  (op_b),
        .op (cmd_op),
        .y  (alu_y),
        .z  (alu_z),
        .c  (alu_c),
        .v  (alu_v)
    );

    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_Z] = alu_z;
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;
    end

    always_comb begin
        regs_d      = regs_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_flags_d = res_flags_q;
        sticky_d    = sticky_q;
        op_count_d  = op_count_q;

        if (cmd_acc && wr_ok) begin
            regs_d[cmd_rd] = cmd_ld ? cmd_imm : alu_y;
        end

        if (alu_acc) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_y;
            res_rd_d    = cmd_rd;
            res_flags_d = alu_flags;
            if (op_count_q != {CNT_W{1'b1}}) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end else if (handoff) begin
            res_valid_d = 1'b0;
        end

        // Clear wins over the OR-in of the same cycle.
        if (sticky_clr) begin
            sticky_d = '0;
        end else if (alu_acc) begin
            sticky_d = sticky_q | alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_flags_q <= '0;
            sticky_q    <= '0;
            op_count_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_flags_q <= res_flags_d;
            sticky_q    <= sticky_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_rd       = res_rd_q;
    assign res_flags    = res_flags_q;
    assign sticky_flags = sticky_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Scoreboard bench for alu_cmd_seq: directed commands push hand-computed beats,
// a monitor pops and compares on every result handoff.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_ld, cmd_imm_en;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_rd, cmd_rs1, cmd_rs2;
    logic [7:0]       cmd_imm;
    logic             res_valid, res_ready;
    logic [7:0]       res_data;
    logic [1:0]       res_rd;
    logic [2:0]       res_flags, sticky_flags;
    logic             sticky_clr;
    logic [CNT_W-1:0] op_count;

    typedef struct packed {
        logic [1:0] rd;
        logic [2:0] flags;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    alu_cmd_seq #(
        .NREG  (4),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ld       (cmd_ld),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm_en   (cmd_imm_en),
        .cmd_imm      (cmd_imm),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_rd       (res_rd),
        .res_flags    (res_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .op_count     (op_count)
    );

    // Monitor: one comparison per handoff.
    always begin : monitor
        beat_t e;
        beat_t got;
        @(negedge clk);
        #1;
        if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            got = {res_rd, res_flags, res_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got rd=%0d flags=%b data=%h, none expected",
                         res_rd, res_flags, res_data);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL beat: got rd=%0d flags=%b data=%h, expected rd=%0d flags=%b data=%h",
                             got.rd, got.flags, got.data, e.rd, e.flags, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a command now (caller is at a negedge) and wait for the accepting edge.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic imm_en,
                         input logic [7:0] imm, input logic clr, input logic push,
                         input logic [7:0] ed, input logic [2:0] ef);
        int    n;
        beat_t b;
        cmd_valid  = 1'b1;
        cmd_ld     = ld;
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm_en = imm_en;
        cmd_imm    = imm;
        sticky_clr = clr;
        #1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end else if (!ld && push) begin
            b.rd    = rd;
            b.flags = ef;
            b.data  = ed;
            exp_q.push_back(b);
        end
        @(posedge clk);
    endtask

    task automatic alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                       input logic [7:0] ed, input logic [2:0] ef);
        @(negedge clk);
        issue(1'b0, op, rd, rs1, rs2, imm_en, imm, 1'b0, 1'b1, ed, ef);
    endtask

    task automatic ld(input logic [1:0] rd, input logic [7:0] imm);
        @(negedge clk);
        issue(1'b1, OP_ADD, rd, 2'd0, 2'd0, 1'b0, imm, 1'b0, 1'b0, 8'h00, 3'b000);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid  = 1'b0;
        sticky_clr = 1'b0;
        #1;
    endtask

    initial begin : stim
        // Reset with a load presented: it must not land in r3.
        rst        = 1'b1;
        res_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_ld     = 1'b1;
        cmd_op     = OP_ADD;
        cmd_rd     = 2'd3;
        cmd_rs1    = 2'd0;
        cmd_rs2    = 2'd0;
        cmd_imm_en = 1'b0;
        cmd_imm    = 8'hAA;
        sticky_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        alu(OP_PASS, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 8'h00, 3'b100);
        idle();
        check("pass_r3_sticky", sticky_flags, 3'b100);
        check("pass_r3_count", op_count, 1);

        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        #1;
        check("sticky_clr_idle", sticky_flags, 0);

        ld(2'd0, 8'h7F);
        ld(2'd1, 8'h01);
        alu(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h80, 3'b001);
        alu(OP_PASS, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 8'h80, 3'b000);
        idle();
        check("add_count", op_count, 3);
        check("add_sticky", sticky_flags, 3'b001);

        // Back-to-back dependent commands on r3.
        alu(OP_SUB, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'h82, 3'b010);
        alu(OP_XOR, 2'd3, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h7D, 3'b000);
        idle();
        check("subxor_count", op_count, 5);
        check("subxor_sticky", sticky_flags, 3'b011);

        // Stall the result stage for three cycles.
        @(negedge clk);
        res_ready = 1'b0;
        issue(1'b0, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h80, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_res_valid", res_valid, 1);
            check("stall_res_data", {res_rd, res_flags, res_data}, {2'd0, 3'b001, 8'h80});
        end
        // Release with a command pending: handoff and accept at the same edge.
        @(negedge clk);
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        issue(1'b0, OP_SHL, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'b110);
        idle();
        check("shl_count", op_count, 7);
        check("shl_sticky", sticky_flags, 3'b111);

        // Clear coincides with an ADD that sets Z, C and V.
        @(negedge clk);
        issue(1'b0, OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h80, 1'b1, 1'b1, 8'h00, 3'b111);
        idle();
        check("clr_vs_add_sticky", sticky_flags, 0);
        check("clr_vs_add_count", op_count, 8);

        ld(2'd1, 8'h05);
        idle();
        check("load_keeps_count", op_count, 8);

        for (int i = 0; i < 10; i++) begin
            alu(OP_OR, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 8'h05, 3'b000);
        end
        idle();
        check("count_saturated", op_count, 4'hF);
        ld(2'd2, 8'h11);
        idle();
        check("load_at_sat", op_count, 4'hF);

        // Reset while a result is stalled: that beat is dropped.
        @(negedge clk);
        res_ready = 1'b0;
        issue(1'b0, OP_AND, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'b100);
        idle();
        check("pre_rst_valid", res_valid, 1);
        check("pre_rst_sticky", sticky_flags, 3'b100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stall_rst_valid", res_valid, 0);
        check("stall_rst_sticky", sticky_flags, 0);
        check("stall_rst_count", op_count, 0);
        res_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            alu(OP_PASS, 2'(r), 2'(r), 2'd0, 1'b0, 8'h00, 8'h00, 3'b100);
        end
        idle();
        check("post_rst_count", op_count, 4);

        @(negedge clk);
        #2;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
